// File: rtl/pipeline_ctrl_unit.sv
// pipeline_ctrl_unit
//   Sequences the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
//   Owns the run/halt state machine and a saturating stall-cycle counter.
// Ports
//   CLK, RST                  clock (rising edge), asynchronous active-high reset
//   ihit, dhit                instruction / data access complete this cycle
//   dmemREN_EX_MEM/WEN        load / store pending in EX/MEM
//   halt_EX_MEM               halt instruction resident in EX/MEM
//   dREN_ID_EX, Rt_ID_EX      load in ID/EX and its destination register
//   Rs_IF_ID, Rt_IF_ID        source registers of the instruction in IF/ID
//   redirect_EX               taken branch / jump resolved in EX
//   pc_en, *_en, *_flush      per-stage capture enables and bubble loads
//   imemREN                   instruction fetch request
//   halt                      sticky processor halt
//   stall_cycles              saturating count of RUN cycles with pc_en=0
module pipeline_ctrl_unit #(
    parameter int REGW  = 5,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmemREN_EX_MEM,
    input  logic             dmemWEN_EX_MEM,
    input  logic             halt_EX_MEM,
    input  logic             dREN_ID_EX,
    input  logic [REGW-1:0]  Rt_ID_EX,
    input  logic [REGW-1:0]  Rs_IF_ID,
    input  logic [REGW-1:0]  Rt_IF_ID,
    input  logic             redirect_EX,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             imemREN,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {RUN, HALT_WB, HALTED} state_t;

    state_t state;

    logic dreq, dstall, adv, loadUse;

    assign dreq    = dmemREN_EX_MEM | dmemWEN_EX_MEM;
    assign dstall  = dreq & ~dhit;
    assign adv     = ihit & ~dstall;
    assign loadUse = dREN_ID_EX & (Rt_ID_EX != '0) &
                     ((Rt_ID_EX == Rs_IF_ID) | (Rt_ID_EX == Rt_IF_ID));

    // A flushed stage always has its enable raised too, so the bubble is
    // actually loaded on the edge; this is why exmem_en accompanies
    // exmem_flush during halt entry and data retirement.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        imemREN     = 1'b0;
        if (!RST) begin
            case (state)
                RUN: begin
                    imemREN = 1'b1;
                    if (halt_EX_MEM && !dstall) begin
                        exmem_en    = 1'b1;
                        exmem_flush = 1'b1;
                        memwb_en    = 1'b1;
                    end else if (dstall) begin
                        // whole pipe frozen
                    end else if (dreq && !ihit) begin
                        exmem_en    = 1'b1;
                        exmem_flush = 1'b1;
                        memwb_en    = 1'b1;
                    end else if (adv && redirect_EX) begin
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_en    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else if (adv && loadUse) begin
                        idex_en    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end else if (adv) begin
                        pc_en    = 1'b1;
                        ifid_en  = 1'b1;
                        idex_en  = 1'b1;
                        exmem_en = 1'b1;
                        memwb_en = 1'b1;
                    end else begin
                        // fetch outstanding, no data request: bubble into ID/EX
                        idex_en    = 1'b1;
                        idex_flush = 1'b1;
                        exmem_en   = 1'b1;
                        memwb_en   = 1'b1;
                    end
                end
                HALT_WB: memwb_en = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= RUN;
            halt         <= 1'b0;
            stall_cycles <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (!pc_en && stall_cycles != '1)
                        stall_cycles <= stall_cycles + CNT_W'(1);
                    if (halt_EX_MEM && !dstall)
                        state <= HALT_WB;
                end
                HALT_WB: begin
                    halt  <= 1'b1;
                    state <= HALTED;
                end
                default: state <= HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Testbench for pipeline_ctrl_unit: directed scenarios followed by random
// stimulus, checked against a stage-action reference model. Two instances
// (default counter width and a 4-bit counter) share the same inputs.
module tb_pipeline_ctrl_unit;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ihit = 1'b0, dhit = 1'b0;
    logic       dmemREN_EX_MEM = 1'b0, dmemWEN_EX_MEM = 1'b0;
    logic       halt_EX_MEM = 1'b0, dREN_ID_EX = 1'b0, redirect_EX = 1'b0;
    logic [4:0] Rt_ID_EX = '0, Rs_IF_ID = '0, Rt_IF_ID = '0;

    logic        pcEnA, ifidEnA, ifidFlA, idexEnA, idexFlA, exEnA, exFlA, wbEnA, imemA, haltA;
    logic [15:0] stallA;
    logic        pcEnB, ifidEnB, ifidFlB, idexEnB, idexFlB, exEnB, exFlB, wbEnB, imemB, haltB;
    logic [3:0]  stallB;

    always #5 CLK = ~CLK;

    pipeline_ctrl_unit dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dmemREN_EX_MEM(dmemREN_EX_MEM), .dmemWEN_EX_MEM(dmemWEN_EX_MEM),
        .halt_EX_MEM(halt_EX_MEM), .dREN_ID_EX(dREN_ID_EX), .Rt_ID_EX(Rt_ID_EX),
        .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID), .redirect_EX(redirect_EX),
        .pc_en(pcEnA), .ifid_en(ifidEnA), .ifid_flush(ifidFlA), .idex_en(idexEnA),
        .idex_flush(idexFlA), .exmem_en(exEnA), .exmem_flush(exFlA), .memwb_en(wbEnA),
        .imemREN(imemA), .halt(haltA), .stall_cycles(stallA)
    );

    pipeline_ctrl_unit #(.REGW(5), .CNT_W(4)) dutNarrow (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dmemREN_EX_MEM(dmemREN_EX_MEM), .dmemWEN_EX_MEM(dmemWEN_EX_MEM),
        .halt_EX_MEM(halt_EX_MEM), .dREN_ID_EX(dREN_ID_EX), .Rt_ID_EX(Rt_ID_EX),
        .Rs_IF_ID(Rs_IF_ID), .Rt_IF_ID(Rt_IF_ID), .redirect_EX(redirect_EX),
        .pc_en(pcEnB), .ifid_en(ifidEnB), .ifid_flush(ifidFlB), .idex_en(idexEnB),
        .idex_flush(idexFlB), .exmem_en(exEnB), .exmem_flush(exFlB), .memwb_en(wbEnB),
        .imemREN(imemB), .halt(haltB), .stall_cycles(stallB)
    );

    int nAsserts = 0;
    int nFails   = 0;

    task automatic checkVal(input string tag, input int unsigned got, input int unsigned exp);
        nAsserts++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each register boundary takes one action per cycle.
    localparam int HOLD = 0, ADV = 1, BUB = 2;
    int          phase;      // 0 running, 1 draining to WB, 2 halted
    logic        mHalt;
    int unsigned mCntWide, mCntNarrow;
    logic        mPcEn;
    logic        mHaltEntry;

    // Order: pc, ifid, idex, exmem, memwb
    function automatic logic [8:0] expectCtrl(output logic pcAdv, output logic haltEntry);
        int  act[5];
        bit  dataWait, dreqNow, hazard;
        logic [8:0] r;
        act = '{HOLD, HOLD, HOLD, HOLD, HOLD};
        haltEntry = 1'b0;
        dreqNow  = dmemREN_EX_MEM || dmemWEN_EX_MEM;
        dataWait = dreqNow && !dhit;
        hazard   = dREN_ID_EX && Rt_ID_EX != 0 && (Rt_ID_EX == Rs_IF_ID || Rt_ID_EX == Rt_IF_ID);
        if (phase == 0) begin
            if (halt_EX_MEM && !dataWait) begin
                act = '{HOLD, HOLD, HOLD, BUB, ADV};
                haltEntry = 1'b1;
            end else if (dataWait)           act = '{HOLD, HOLD, HOLD, HOLD, HOLD};
            else if (dreqNow && !ihit)       act = '{HOLD, HOLD, HOLD, BUB, ADV};
            else if (ihit && redirect_EX)    act = '{ADV, BUB, BUB, ADV, ADV};
            else if (ihit && hazard)         act = '{HOLD, HOLD, BUB, ADV, ADV};
            else if (ihit)                   act = '{ADV, ADV, ADV, ADV, ADV};
            else                             act = '{HOLD, HOLD, BUB, ADV, ADV};
        end else if (phase == 1) begin
            act[4] = ADV;
        end
        r[8] = act[0] == ADV;
        r[7] = act[1] != HOLD; r[6] = act[1] == BUB;
        r[5] = act[2] != HOLD; r[4] = act[2] == BUB;
        r[3] = act[3] != HOLD; r[2] = act[3] == BUB;
        r[1] = act[4] != HOLD;
        r[0] = phase == 0;
        pcAdv = r[8];
        return r;
    endfunction

    task automatic checkAll(input logic [8:0] expCtrl, input logic expHalt,
                            input int unsigned expWide, input int unsigned expNarrow);
        checkVal("ctrl", {pcEnA, ifidEnA, ifidFlA, idexEnA, idexFlA, exEnA, exFlA, wbEnA, imemA}, expCtrl);
        checkVal("ctrlNarrow", {pcEnB, ifidEnB, ifidFlB, idexEnB, idexFlB, exEnB, exFlB, wbEnB, imemB}, expCtrl);
        checkVal("halt", haltA, expHalt);
        checkVal("haltNarrow", haltB, expHalt);
        checkVal("stall_cycles", stallA, expWide);
        checkVal("stallNarrow", stallB, expNarrow);
    endtask

    task automatic doReset();
        RST = 1'b1;
        #1;
        checkAll('0, 1'b0, 0, 0);
        phase = 0; mHalt = 1'b0; mCntWide = 0; mCntNarrow = 0;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Inputs are applied at the falling edge before calling this.
    task automatic cycle();
        logic [8:0] exp;
        #1;
        exp = expectCtrl(mPcEn, mHaltEntry);
        checkAll(exp, mHalt, mCntWide, mCntNarrow);
        @(posedge CLK);
        if (phase == 0 && !mPcEn) begin
            if (mCntWide < 65535) mCntWide++;
            if (mCntNarrow < 15) mCntNarrow++;
        end
        if (phase == 0 && mHaltEntry) phase = 1;
        else if (phase == 1) begin phase = 2; mHalt = 1'b1; end
        @(negedge CLK);
    endtask

    task automatic clearInputs();
        ihit = 1'b0; dhit = 1'b0; dmemREN_EX_MEM = 1'b0; dmemWEN_EX_MEM = 1'b0;
        halt_EX_MEM = 1'b0; dREN_ID_EX = 1'b0; redirect_EX = 1'b0;
        Rt_ID_EX = '0; Rs_IF_ID = '0; Rt_IF_ID = '0;
    endtask

    initial begin
        phase = 0; mHalt = 1'b0; mCntWide = 0; mCntNarrow = 0;
        @(negedge CLK);
        doReset();

        // Free-running pipe
        clearInputs(); ihit = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Load-use on rs
        dREN_ID_EX = 1'b1; Rt_ID_EX = 5'd5; Rs_IF_ID = 5'd5;
        cycle();
        dREN_ID_EX = 1'b0;
        cycle();

        // r0 destination never stalls; redirect overrides load-use
        dREN_ID_EX = 1'b1; Rt_ID_EX = 5'd0; Rs_IF_ID = 5'd0;
        cycle();
        Rt_ID_EX = 5'd5; Rs_IF_ID = 5'd5; redirect_EX = 1'b1;
        cycle();
        clearInputs(); ihit = 1'b1;

        // Data miss for three cycles, then hit
        doReset();
        dmemREN_EX_MEM = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        dhit = 1'b1;
        cycle();
        clearInputs(); ihit = 1'b1;
        cycle();

        // Halt sequence, then reset recovery
        halt_EX_MEM = 1'b1;
        cycle();
        halt_EX_MEM = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        doReset();
        cycle();

        // Long fetch stall: narrow counter saturates
        clearInputs();
        for (int i = 0; i < 21; i++) cycle();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) doReset();
            ihit           = $urandom_range(0, 3) != 0;
            dhit           = $urandom_range(0, 2) != 0;
            dmemREN_EX_MEM = $urandom_range(0, 3) == 0;
            dmemWEN_EX_MEM = $urandom_range(0, 5) == 0;
            halt_EX_MEM    = $urandom_range(0, 49) == 0;
            dREN_ID_EX     = $urandom_range(0, 2) == 0;
            redirect_EX    = $urandom_range(0, 5) == 0;
            Rt_ID_EX       = 5'($urandom_range(0, 3));
            Rs_IF_ID       = 5'($urandom_range(0, 3));
            Rt_IF_ID       = 5'($urandom_range(0, 3));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
